// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronises rxd, decodes frames and hands bytes over a valid/ready port.
// Define UART_RX_PARITY_EN for 8E1 framing with an added parity_err output.
module uart_rx_deframer #(
    parameter int BIT_CYCLES  = 868,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYCLES - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   valid_q, valid_d;
    logic [7:0]             data_q, data_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rxd_s;
    logic                   deliver;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   parity_err_q, parity_err_d;
`endif

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], rxd};
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        valid_d      = valid_q & ~rx_ready;
        data_d       = data_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        deliver      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = rxd_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rxd_s) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end else begin
                        deliver = 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            parity_err_d = 1'b1;
                            deliver      = 1'b0;
                        end
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BREAK: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A same-cycle consume frees the holding register for the incoming byte.
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_valid  = valid_q;
    assign rx_data   = data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: expected bytes queued at send time, popped on handshake.
module tb_uart_rx_deframer;

    localparam int B   = 16;
    localparam int SS  = 2;
    localparam int H   = B / 2;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = SS + H + 10 * B + 1;
`else
    localparam int LAT = SS + H + 9 * B + 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    int         pe_cnt = 0;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         fe_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] exp_q[$];
    logic       valid_prev = 1'b0;
    logic       ready_prev = 1'b0;

    uart_rx_deframer #(.BIT_CYCLES(B), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
        rxd = 1'b0;
        fall_cyc = cyc;
        wait_cycles(B);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(B);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        wait_cycles(B);
`endif
        rxd = stop;
        wait_cycles(B);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && !valid_prev)
                check("latency", cyc - fall_cyc, LAT);
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) check("spurious_valid", {31'd0, rx_valid}, 32'd0);
                else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
            if (rx_valid && valid_prev && ready_prev)
                check("hold_1cyc", {31'd0, rx_valid}, 32'd0);
            if (frame_err && overrun)
                check("fe_ovr_excl", {31'd0, overrun}, 32'd0);
            if (frame_err) fe_cnt++;
            if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
        end
        valid_prev <= rx_valid;
        ready_prev <= rx_ready;
    end

    initial begin
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(1);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulses", {30'd0, frame_err, overrun}, 32'd0);

        wait_cycles(200);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_valid", {31'd0, rx_valid}, 32'd0);
        check("idle_data", {24'd0, rx_data}, 32'd0);

        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b0);
        wait_cycles(20);
        check("a5_fe", fe_cnt, 0);

        rxd = 1'b0;
        wait_cycles(5);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        wait_cycles(H + 10);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("glitch_fe", fe_cnt, 0);

        send_byte(8'h3C, 1'b0, 1'b0);
        wait_cycles(50);
        check("break_busy", {31'd0, busy}, 32'd1);
        wait_cycles(50);
        check("break_fe", fe_cnt, 1);
        rxd = 1'b1;
        wait_cycles(10);
        check("break_exit", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1, 1'b0);
        wait_cycles(20);
        check("after_break_fe", fe_cnt, 1);

        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        wait_cycles(10);
        check("ovr_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_data", {24'd0, rx_data}, 32'h11);
        check("ovr_cnt", ovr_cnt, 1);
        rx_ready = 1'b1;
        wait_cycles(2);
        check("ovr_drain", {31'd0, rx_valid}, 32'd0);

        begin
            logic [7:0] b;
            b = 8'h5A;
            rxd = 1'b0;
            fall_cyc = cyc;
            wait_cycles(B);
            for (int i = 0; i < 4; i++) begin
                rxd = b[i];
                wait_cycles(B);
            end
            rxd = b[4];
            wait_cycles(H);
            check("mid_busy", {31'd0, busy}, 32'd1);
            reset = 1'b1;
            rxd = 1'b1;
            wait_cycles(1);
            reset = 1'b0;
            wait_cycles(30);
            check("mid_rst_busy", {31'd0, busy}, 32'd0);
            check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        end
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1, 1'b0);
        wait_cycles(20);

`ifdef UART_RX_PARITY_EN
        send_byte(8'h07, 1'b1, 1'b1);
        wait_cycles(20);
        check("parity_err_cnt", pe_cnt, 1);
`endif

        check("final_fe", fe_cnt, 1);
        check("final_ovr", ovr_cnt, 1);
        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
